// File: rtl/fetch_packet_queue_if.sv
// Handshake bundle between the fetch stage, the packet queue and the decoder.
// The master side is the fetch stage plus decoder; the slave side is the queue.
interface fetch_packet_queue_if #(
  parameter int PACKET_SIZE = 64,
  parameter int DEPTH       = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [2*PACKET_SIZE-1:0] data_in;
  logic                     valid_in;
  logic                     ready_o;
  logic                     must_flush;
  logic [1:0]               pop_cnt;
  logic [PACKET_SIZE-1:0]   pkt_a_o;
  logic [PACKET_SIZE-1:0]   pkt_b_o;
  logic                     valid_a_o;
  logic                     valid_b_o;
  logic [CW-1:0]            count_o;

  modport master (
    output data_in, valid_in, must_flush, pop_cnt,
    input  ready_o, pkt_a_o, pkt_b_o, valid_a_o, valid_b_o, count_o
  );

  modport slave (
    input  data_in, valid_in, must_flush, pop_cnt,
    output ready_o, pkt_a_o, pkt_b_o, valid_a_o, valid_b_o, count_o
  );
endinterface

// File: rtl/fetch_packet_queue.sv
// Circular buffer between fetch and decode: accepts 2-packet bundles,
// presents the two oldest packets, and lets decode consume 0..2 per cycle.
module fetch_packet_queue #(
  parameter int PACKET_SIZE = 64,
  parameter int DEPTH       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_packet_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PACKET_SIZE-1:0] storage [DEPTH];

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          ready_q;

  logic [PW-1:0] head_b, tail_b;
  logic [CW-1:0] pop_req, pop_eff, count_next;
  logic          push, flush;

  assign flush  = bus.must_flush;
  assign push   = bus.valid_in && ready_q && !flush;
  assign head_b = head_q + PW'(1);
  assign tail_b = tail_q + PW'(1);

  // Decode may ask for more than is stored; clamp to the current occupancy.
  always_comb begin
    pop_req    = CW'(bus.pop_cnt);
    pop_eff    = (pop_req > count_q) ? count_q : pop_req;
    count_next = count_q + (push ? CW'(2) : CW'(0)) - pop_eff;
  end

  // Storage holds no reset value; both bundle halves land in consecutive slots.
  always_ff @(posedge clk) begin
    if (push) begin
      storage[tail_q] <= bus.data_in[PACKET_SIZE-1:0];
      storage[tail_b] <= bus.data_in[2*PACKET_SIZE-1:PACKET_SIZE];
    end
  end

  // Pointer, occupancy and ready bookkeeping; ready looks one cycle ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      head_q  <= head_q + PW'(pop_eff);
      if (push) tail_q <= tail_q + PW'(2);
      count_q <= count_next;
      ready_q <= (count_next <= CW'(DEPTH - 2));
    end
  end

  assign bus.ready_o   = ready_q;
  assign bus.pkt_a_o   = storage[head_q];
  assign bus.pkt_b_o   = storage[head_b];
  assign bus.valid_a_o = (count_q >= CW'(1));
  assign bus.valid_b_o = (count_q >= CW'(2));
  assign bus.count_o   = count_q;

  // Decode must never pop 3 or more packets than are stored.
  pop_legal_a: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.pop_cnt != 2'd3) && (CW'(bus.pop_cnt) <= count_q))
    else $error("fetch_packet_queue: illegal pop_cnt %0d with count %0d", bus.pop_cnt, count_q);
endmodule
